// File: rtl/sync_fifo.sv
// Single-clock FIFO with count-decoded occupancy flags and registered
// handshake/error pulses; depth need not be a power of two.
module sync_fifo #(
   parameter int FIFO_WIDTH = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [FIFO_WIDTH-1:0] data_in,
   output logic [FIFO_WIDTH-1:0] data_out,
   output logic                  wr_ack,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  full,
   output logic                  almostfull,
   output logic                  empty,
   output logic                  almostempty
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

   logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;
   logic [FIFO_WIDTH-1:0] r_data_out;
   logic                  r_wr_ack;
   logic                  r_overflow;
   logic                  r_underflow;

   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic                  w_full;
   logic                  w_empty;

   assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_empty  = (r_count == '0);
   assign w_wr_acc = wr_en && !w_full;
   assign w_rd_acc = rd_en && !w_empty;

   // Storage is never cleared; reset only blocks a write in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst && w_wr_acc)
         r_mem[r_wr_ptr] <= data_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_data_out  <= '0;
         r_wr_ack    <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_wr_ack    <= w_wr_acc;
         r_overflow  <= wr_en && w_full;
         r_underflow <= rd_en && w_empty;
         if (w_wr_acc)
            r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
         if (w_rd_acc) begin
            r_data_out <= r_mem[r_rd_ptr];
            r_rd_ptr   <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
         end
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign data_out    = r_data_out;
   assign wr_ack      = r_wr_ack;
   assign overflow    = r_overflow;
   assign underflow   = r_underflow;
   assign full        = w_full;
   assign empty       = w_empty;
   assign almostfull  = (r_count == CNT_W'(FIFO_DEPTH - 1));
   assign almostempty = (r_count == CNT_W'(1));

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: a queue scoreboard tracks accepted
// writes and predicts read data, pulses and occupancy flags.
module tb_sync_fifo;

   localparam int W = 16;
   localparam int D = 8;

   logic         clk;
   logic         rst;
   logic         wr_en;
   logic         rd_en;
   logic [W-1:0] data_in;
   logic [W-1:0] data_out;
   logic         wr_ack;
   logic         overflow;
   logic         underflow;
   logic         full;
   logic         almostfull;
   logic         empty;
   logic         almostempty;

   sync_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .rd_en       (rd_en),
      .data_in     (data_in),
      .data_out    (data_out),
      .wr_ack      (wr_ack),
      .overflow    (overflow),
      .underflow   (underflow),
      .full        (full),
      .almostfull  (almostfull),
      .empty       (empty),
      .almostempty (almostempty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [W-1:0] sb[$];
   int           m_count = 0;
   logic [W-1:0] exp_dout = '0;
   logic         exp_ack = 1'b0;
   logic         exp_ovf = 1'b0;
   logic         exp_unf = 1'b0;

   function automatic logic [3:0] exp_flags();
      return {m_count == D, m_count == D - 1, m_count == 1, m_count == 0};
   endfunction

   // Drives one cycle, updates the model, and returns at the next falling edge.
   task automatic drive(input logic r_s, input logic w, input logic r, input logic [W-1:0] d);
      logic wa, ra;
      rst = r_s; wr_en = w; rd_en = r; data_in = d;
      if (r_s) begin
         m_count = 0; sb.delete();
         exp_dout = '0; exp_ack = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
      end else begin
         wa = w && (m_count < D);
         ra = r && (m_count > 0);
         exp_ack = wa;
         exp_ovf = w && (m_count == D);
         exp_unf = r && (m_count == 0);
         if (ra) exp_dout = sb.pop_front();
         if (wa) sb.push_back(d);
         m_count = m_count + int'(wa) - int'(ra);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b1, 1'b0, 16'hAAAA);
         n_cmp++;
         if ({full, almostfull, almostempty, empty} !== 4'b0001) begin
            n_err++; $display("FAIL reset_flags: got %b want 0001", {full, almostfull, almostempty, empty});
         end
         n_cmp++;
         if (data_out !== 16'h0000) begin
            n_err++; $display("FAIL reset_dout: got %h want 0000", data_out);
         end
         n_cmp++;
         if ({wr_ack, overflow, underflow} !== 3'b000) begin
            n_err++; $display("FAIL reset_pulses: got %b want 000", {wr_ack, overflow, underflow});
         end
      end
   endtask

   task automatic test_fill();
      for (int i = 1; i <= D + 1; i++) begin
         drive(1'b0, 1'b1, 1'b0, W'(i));
         n_cmp++;
         if ({wr_ack, overflow} !== {exp_ack, exp_ovf}) begin
            n_err++; $display("FAIL fill_pulses[%0d]: got ack/ovf %b want %b", i, {wr_ack, overflow}, {exp_ack, exp_ovf});
         end
         n_cmp++;
         if ({full, almostfull, almostempty, empty} !== exp_flags()) begin
            n_err++; $display("FAIL fill_flags[%0d]: got %b want %b", i, {full, almostfull, almostempty, empty}, exp_flags());
         end
      end
      n_cmp++;
      if ({full, overflow, wr_ack} !== 3'b110) begin
         n_err++; $display("FAIL fill_overflow: got full/ovf/ack %b want 110", {full, overflow, wr_ack});
      end
      drive(1'b0, 1'b0, 1'b0, '0);
      n_cmp++;
      if (overflow !== 1'b0) begin
         n_err++; $display("FAIL fill_ovf_single: got %b want 0", overflow);
      end
   endtask

   task automatic test_drain();
      for (int i = 1; i <= D + 1; i++) begin
         drive(1'b0, 1'b0, 1'b1, '0);
         n_cmp++;
         if (data_out !== exp_dout) begin
            n_err++; $display("FAIL drain_data[%0d]: got %h want %h", i, data_out, exp_dout);
         end
         n_cmp++;
         if ({full, almostfull, almostempty, empty} !== exp_flags()) begin
            n_err++; $display("FAIL drain_flags[%0d]: got %b want %b", i, {full, almostfull, almostempty, empty}, exp_flags());
         end
         n_cmp++;
         if (underflow !== exp_unf) begin
            n_err++; $display("FAIL drain_unf[%0d]: got %b want %b", i, underflow, exp_unf);
         end
      end
      n_cmp++;
      if ({data_out, underflow} !== {16'h0008, 1'b1}) begin
         n_err++; $display("FAIL drain_hold: got %h/%b want 0008/1", data_out, underflow);
      end
   endtask

   task automatic test_sim_empty();
      drive(1'b0, 1'b1, 1'b1, 16'h1234);
      n_cmp++;
      if ({wr_ack, underflow, almostempty, empty} !== 4'b1110) begin
         n_err++; $display("FAIL sim_empty_flags: got ack/unf/ae/e %b want 1110", {wr_ack, underflow, almostempty, empty});
      end
      n_cmp++;
      if (data_out !== 16'h0008) begin
         n_err++; $display("FAIL sim_empty_dout: got %h want 0008", data_out);
      end
   endtask

   task automatic test_sim_partial_full();
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, W'(16'h2000 + i));
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b1, 1'b1, W'(16'h3000 + i));
         n_cmp++;
         if ({data_out, wr_ack} !== {exp_dout, 1'b1}) begin
            n_err++; $display("FAIL sim_partial[%0d]: got %h/%b want %h/1", i, data_out, wr_ack, exp_dout);
         end
         n_cmp++;
         if ({full, almostfull, almostempty, empty} !== 4'b0000 || m_count != 4) begin
            n_err++; $display("FAIL sim_partial_cnt[%0d]: got %b want 0000", i, {full, almostfull, almostempty, empty});
         end
      end
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, W'(16'h4000 + i));
      n_cmp++;
      if (full !== 1'b1) begin
         n_err++; $display("FAIL sim_full_pre: got full %b want 1", full);
      end
      drive(1'b0, 1'b1, 1'b1, 16'h5555);
      n_cmp++;
      if ({almostfull, full, overflow, wr_ack} !== 4'b1010) begin
         n_err++; $display("FAIL sim_full_flags: got af/f/ovf/ack %b want 1010", {almostfull, full, overflow, wr_ack});
      end
      n_cmp++;
      if (data_out !== exp_dout || exp_dout !== 16'h3006) begin
         n_err++; $display("FAIL sim_full_dout: got %h want 3006", data_out);
      end
   endtask

   task automatic test_mid_reset();
      drive(1'b0, 1'b0, 1'b1, '0);
      drive(1'b0, 1'b0, 1'b1, '0);
      n_cmp++;
      if ({full, almostfull, almostempty, empty} !== exp_flags() || m_count != 5) begin
         n_err++; $display("FAIL mid_pre: got %b want 0000 at count 5", {full, almostfull, almostempty, empty});
      end
      drive(1'b1, 1'b0, 1'b0, '0);
      n_cmp++;
      if ({empty, data_out} !== {1'b1, 16'h0000}) begin
         n_err++; $display("FAIL mid_reset: got e/dout %b/%h want 1/0000", empty, data_out);
      end
      drive(1'b0, 1'b1, 1'b0, 16'hBEEF);
      drive(1'b0, 1'b0, 1'b1, '0);
      n_cmp++;
      if ({data_out, empty} !== {16'hBEEF, 1'b1} || exp_dout !== 16'hBEEF) begin
         n_err++; $display("FAIL mid_read: got dout/e %h/%b want BEEF/1", data_out, empty);
      end
   endtask

   initial begin
      rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
      @(negedge clk);
      test_reset();
      test_fill();
      test_drain();
      test_sim_empty();
      test_sim_partial_full();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
